// File: rtl/stall_ctrl.sv
// Pipeline stall/flush controller: RUN / MEM_WAIT / HALTED state plus combinational enables and flushes.
// Optional stall-cycle counter and stall_count port are present only when STALL_COUNT_EN is defined.
module stall_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs,
  input  logic [REG_ADDR_WIDTH-1:0] id_rt,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
  input  logic                      ex_mem_read,
  input  logic                      ex_branch_taken,
  input  logic                      mem_wait,
  input  logic                      halt,
  output logic                      pc_en,
  output logic                      ifid_en,
  output logic                      idex_en,
  output logic                      exmem_en,
  output logic                      memwb_en,
  output logic                      ifid_flush,
  output logic                      idex_flush,
  output logic                      exmem_flush,
  output logic                      memwb_flush
`ifdef STALL_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      stall_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALTED   = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   load_use;

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (ex_rd == id_rt));

  // NOTE: every output and next-state gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;

    if (!rst) begin
      state_d     = RUN;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      memwb_flush = 1'b1;
    end else if (state_q == HALTED || halt) begin
      state_d  = HALTED;
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (mem_wait) begin
      // Freeze upstream; MEM result is invalid, so WB receives a bubble.
      state_d     = MEM_WAIT;
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else begin
      state_d = RUN;
      if (ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

`ifdef STALL_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  // Saturating count of stalled cycles; the halt-entry cycle counts, HALTED cycles do not.
  always_comb begin
    cnt_d = cnt_q;
    if (!pc_en && state_q != HALTED && cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;
`endif

endmodule

// File: doc/stall_ctrl.md
STALL_CTRL -- requirements
Module: stall_ctrl

Interface
REQ-001 Parameter REG_ADDR_WIDTH, default 5: width of register-address inputs.
REQ-002 Parameter CNT_WIDTH, default 32: width of stall_count.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-005 id_rs, id_rt  input  REG_ADDR_WIDTH each  source registers of the instruction in ID.
REQ-006 ex_rd  input  REG_ADDR_WIDTH  destination register of the instruction in EX.
REQ-007 ex_mem_read  input  1  instruction in EX is a load.
REQ-008 ex_branch_taken  input  1  instruction in EX resolves as a taken branch or jump.
REQ-009 mem_wait  input  1  data memory busy, so MEM cannot complete this cycle.
REQ-010 halt  input  1  halt instruction is retiring in WB.
REQ-011 pc_en, ifid_en, idex_en, exmem_en, memwb_en  output  1 each  enables to the PC and to the pipeline registers.
REQ-012 ifid_flush, idex_flush, exmem_flush, memwb_flush  output  1 each  clear (bubble insert) to the pipeline registers.
REQ-013 stall_count  output  CNT_WIDTH  stall-cycle counter; port exists only when STALL_COUNT_EN is defined.

Function
REQ-014 The block SHALL hold a state register with states RUN, MEM_WAIT and HALTED; enables and flushes SHALL be combinational from state and inputs.
REQ-015 The block SHALL evaluate conditions in this priority order: HALTED, then halt, then mem_wait, then ex_branch_taken, then load-use, then normal.
REQ-016 Load-use SHALL be defined as ex_mem_read=1, ex_rd!=0, and (ex_rd==id_rs or ex_rd==id_rt).
REQ-017 Normal (RUN, no condition active): all enables=1, all flushes=0.
REQ-018 Load-use: pc_en=0, ifid_en=0, idex_flush=1, all other enables=1; this lasts exactly one cycle and needs no state change.
REQ-019 Branch: all enables=1, ifid_flush=1, idex_flush=1, other flushes=0; it SHALL override a load-use detected in the same cycle.
REQ-020 mem_wait=1 (in RUN or MEM_WAIT): pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=1, memwb_flush=1, other flushes=0.
REQ-021 A pending branch or load-use SHALL be masked while frozen and re-evaluated on the first cycle mem_wait=0.
REQ-022 State transitions: RUN->MEM_WAIT when mem_wait=1; MEM_WAIT->RUN when mem_wait=0; any state->HALTED when halt=1.
REQ-023 During a mem_wait=0 cycle in MEM_WAIT, outputs SHALL follow the RUN rules.
REQ-024 halt=1 cycle and all HALTED cycles: all enables=0, all flushes=0.
REQ-025 HALTED SHALL be sticky until reset.

Reset
REQ-026 When rst=0 at posedge clk: state<=RUN and stall_count<=0.
REQ-027 While rst=0, outputs SHALL be all enables=0 and all flushes=1, regardless of other inputs.
REQ-028 Reset asserted in MEM_WAIT or HALTED SHALL return the block to RUN on the next edge; there is no residual freeze.

Configuration
REQ-029 Macro STALL_COUNT_EN defined: stall_count SHALL increment by 1 on each rising clock edge where rst=1, pc_en=0 and state!=HALTED (the halt-entry cycle included).
REQ-030 With STALL_COUNT_EN defined, stall_count SHALL saturate at all-ones and never wrap.
REQ-031 Macro STALL_COUNT_EN undefined: the stall_count port and the counter logic SHALL be absent; all other behaviour is identical.

Verification
REQ-032 ex_mem_read=1, ex_rd=5, id_rs=5 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; normal outputs the next cycle.
REQ-033 Load-use with ex_rd=0 -> no stall, all enables=1.
REQ-034 ex_branch_taken=1 together with a load-use hit -> ifid_flush=idex_flush=1, pc_en=1, no stall.
REQ-035 mem_wait=1 for 3 cycles with ex_branch_taken=1 throughout -> 3 freeze cycles with memwb_flush=1; branch flush on the 4th cycle; stall_count=3 when STALL_COUNT_EN is defined.
REQ-036 halt=1 pulse, then mem_wait toggled -> all enables=0 held indefinitely; rst=0 for 1 cycle -> state RUN, stall_count=0, normal outputs after release.
REQ-037 STALL_COUNT_EN defined, CNT_WIDTH=4, 20 consecutive mem_wait cycles -> stall_count holds at 15.
